// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port controller.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 8;
  localparam int unsigned RF_ADDR_W = 3;
  localparam int unsigned RF_DEPTH  = 2 ** RF_ADDR_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_LOAD = 1;
  localparam int unsigned REQ_EXT  = 2;

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Valid/ready write-request bundle between the writeback sources and the controller.
interface regfile_write_ctrl_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 3
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_write_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               any_grant
);

  int unsigned sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = 32'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PTR_W'(sum);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        winner     = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Owns the register-file write port: init sweep after reset / init_req, then
// round-robin sharing between writeback sources with a 1-cycle registered write.
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned       NUM_REQ    = 3,
  parameter int unsigned       DATA_W     = RF_DATA_W,
  parameter int unsigned       ADDR_W     = RF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_req,
  regfile_write_ctrl_if.slave  req_if,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 init_done
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  ctrl_state_t       state_q, state_d;
  logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              we_d, done_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   winner;
  logic               any_grant;
  logic               accept;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_if.req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_if.req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req       (req_if.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // Grants are only visible once the sweep has completed.
  assign req_if.req_ready = init_done ? grant : '0;
  assign accept           = init_done & any_grant;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    we_d       = 1'b0;
    waddr_d    = rf_waddr;
    wdata_d    = rf_wdata;
    done_d     = init_done;

    case (state_q)
      INIT: begin
        done_d     = 1'b0;
        we_d       = 1'b1;
        waddr_d    = ADDR_W'(init_cnt_q);
        wdata_d    = INIT_VALUE;
        init_cnt_d = init_cnt_q + CNT_W'(1);
        if (init_cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
        if (init_req) begin
          state_d    = INIT;
          init_cnt_d = '0;
        end
      end

      RUN: begin
        done_d = 1'b1;
        if (accept) begin
          we_d     = 1'b1;
          waddr_d  = addr_arr[winner];
          wdata_d  = data_arr[winner];
          rr_ptr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
        end
        // A same-cycle accepted write still lands; the sweep overwrites it.
        if (init_req) begin
          state_d    = INIT;
          init_cnt_d = '0;
          rr_ptr_d   = '0;
          done_d     = 1'b0;
        end
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      rr_ptr_q   <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      init_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_we      <= we_d;
      rf_waddr   <= waddr_d;
      rf_wdata   <= wdata_d;
      init_done  <= done_d;
    end
  end

endmodule

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
- Controller that owns the single write port of the 8x8 register file.
- After reset it sequences an initialisation sweep that writes INIT_VALUE into every register, because the register bank itself has no reset.
- It then shares the write port between NUM_REQ writeback sources (ALU, load path, external/debug) using round-robin arbitration with a valid/ready handshake.
- Its outputs drive the register file's reg_write, write_addr and write_data directly.

Parameters:
- NUM_REQ, 3, number of write requesters (2..4).
- DATA_W, 8, register data width.
- ADDR_W, 3, register address width; register count = 2**ADDR_W.
- INIT_VALUE, 0, value written to every register during the init sweep.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- init_req  input  1  single-cycle pulse; restarts the init sweep.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed data; same packing as req_addr.
- req_ready  output  NUM_REQ  one-hot grant; combinational.
- rf_we  output  1  register-file write enable; registered.
- rf_waddr  output  ADDR_W  register-file write address; registered.
- rf_wdata  output  DATA_W  register-file write data; registered.
- init_done  output  1  high while in RUN; registered.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, rr_ptr=0, init_cnt=0, state=INIT. req_ready=0 because init_done=0.
- State INIT:
  - On each rising edge, rf_we<=1, rf_waddr<=init_cnt, rf_wdata<=INIT_VALUE, init_cnt<=init_cnt+1.
  - The edge that issues address 2**ADDR_W-1 also sets state<=RUN and init_cnt<=0.
  - On the next edge, rf_we<=0 unless a grant occurred, and init_done<=1.
  - With defaults: edges 1..8 after reset release write addresses 0..7; init_done rises at edge 9.
- req_ready: all zeros unless init_done=1.
- State RUN arbitration:
  - Search req_valid starting at index rr_ptr, ascending with wrap modulo NUM_REQ. The first valid index w wins.
  - req_ready has only bit w set; all other bits are 0, even if those requesters are valid.
  - No valid requester gives req_ready=0.
- Accept: req_valid[w] && req_ready[w]. At most one accept per cycle.
  - On the following edge: rf_we<=1, rf_waddr<=req_addr[w], rf_wdata<=req_data[w], rr_ptr<=(w+1) mod NUM_REQ.
  - Latency from accept to register-file write edge: 1 cycle. Throughput: 1 write per cycle.
- Idle cycle (no accept): rf_we<=0. rf_waddr and rf_wdata hold their values. rr_ptr holds.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- init_req in RUN:
  - On the next edge, state<=INIT, init_cnt<=0, init_done<=0.
  - A grant accepted in the same cycle as init_req is still written on that edge; the sweep follows and overwrites it.
  - rr_ptr resets to 0.
- init_req in INIT: the sweep restarts from address 0.
- Asynchronous reset mid-sweep or mid-write: all registered outputs return to their reset values immediately. Any in-flight write is dropped.
- Requester protocol:
  - A requester holds req_addr and req_data stable while req_valid=1 and it has not been accepted.
  - A requester may deassert req_valid without acceptance (no penalty).
- Width rules:
  - init_cnt is ADDR_W+1 bits wide so the terminal count is detected without wrap ambiguity.
  - rr_ptr is clog2(NUM_REQ) bits wide and wraps explicitly at NUM_REQ.

Decomposition:
- Shared package regfile_pkg:
  - constants RF_DATA_W=8, RF_ADDR_W=3, RF_DEPTH=8;
  - state enum ctrl_state_t {INIT, RUN};
  - requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_EXT=2.
- Sub-module rr_arbiter: purely combinational round-robin pick. Inputs: req vector and rr_ptr. Outputs: one-hot grant, winner index, any_grant. This keeps the sequencing FSM separate from arbitration and lets the arbiter be reused for a future read-port sharer.

Test Plan:
- Reset release, no requests:
  - rf_we=1 for 8 cycles with rf_waddr=0..7 and rf_wdata=0x00;
  - init_done=1 at cycle 9; rf_we=0 thereafter;
  - register file reads 0x00 at all addresses.
- During INIT hold req_valid=3'b111 → req_ready=0 throughout. First grant after init_done goes to requester 0 (rr_ptr=0).
- Single request: requester 1 sends addr=5, data=0xA7 → req_ready=3'b010 same cycle. Next edge: rf_we=1, rf_waddr=5, rf_wdata=0xA7. Register file read_data of addr 5 returns 0xA7 afterwards.
- All three continuously valid with data 0x11/0x22/0x33 to addr 1/2/3 → grant order 0,1,2,0,1,2. rf_waddr sequence 1,2,3,1,2,3 on consecutive cycles with no bubbles.
- Requester 2 accepted (addr=4, data=0x5C) in the same cycle init_req=1 → edge 1 writes addr 4 = 0x5C, init_done=0. The sweep then writes 0..7 = 0x00 and addr 4 ends at 0x00. init_done returns after 8 sweep writes.
- Assert rst_n=0 asynchronously mid-sweep (after address 3) → rf_we, rf_waddr, rf_wdata, init_done go to 0 without a clock edge. After release, the sweep restarts at address 0.
